instruction_fetcher: RTL and testbench

Upstream feeder for the instruction decoder. Walks instruction memory from a start address, reads one 32-bit instruction per step, and hands it to the decoder over its start/ready handshake. Holds each instruction stable on the decoder's instruction input until the decoder reports ready, then advances. Stops at a halt opcode.

---
 rtl/instruction_fetcher_if.sv | 47 ++++
 rtl/instruction_fetcher.sv | 105 ++++++++++
 tb/tb_instruction_fetcher.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetcher_if.sv
// ----------------------------------------------------------------------------
// instruction_fetcher_if
// Bundles the fetcher's control, instruction-memory and decoder-handshake
// signals.
//   master : the fetcher side (drives the memory strobe/address, the decoder
//            start/instruction, and the status outputs)
//   slave  : the environment side (drives run/base_addr, memory read data and
//            decoder_ready)
// Signals:
//   run, base_addr          start request and first fetch address
//   imem_rd_en, imem_addr   memory read strobe/address
//   imem_data               read data, valid one cycle after imem_rd_en
//   instruction_out         instruction held for the decoder
//   decoder_start           one-cycle start pulse
//   decoder_ready           one-cycle completion pulse
//   pc, instr_count         fetch address and issued-instruction count
//   busy, halted            status
// ----------------------------------------------------------------------------
interface instruction_fetcher_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  run;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic                  imem_rd_en;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [WIDTH-1:0]      imem_data;
    logic [WIDTH-1:0]      instruction_out;
    logic                  decoder_start;
    logic                  decoder_ready;
    logic [ADDR_WIDTH-1:0] pc;
    logic [15:0]           instr_count;
    logic                  busy;
    logic                  halted;

    modport master (
        input  run, base_addr, imem_data, decoder_ready,
        output imem_rd_en, imem_addr, instruction_out, decoder_start,
               pc, instr_count, busy, halted
    );

    modport slave (
        output run, base_addr, imem_data, decoder_ready,
        input  imem_rd_en, imem_addr, instruction_out, decoder_start,
               pc, instr_count, busy, halted
    );
endinterface

// File: rtl/instruction_fetcher.sv
// ----------------------------------------------------------------------------
// instruction_fetcher
// Walks instruction memory from base_addr, reads one instruction per step and
// hands it to the decoder over its start/ready handshake. Stops on an
// instruction whose top byte equals HALT_OPCODE; that instruction is latched
// but never issued.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low
//   bus    instruction_fetcher_if.master (see interface header)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | after reset, waiting for run
// FETCH    | read strobe out, imem_addr = pc
// LATCH    | capture read data; halt opcode -> HALT, otherwise -> ISSUE
// ISSUE    | decoder_start high for this one cycle
// WAIT_DEC | hold instruction, wait for decoder_ready
// HALT     | halt opcode seen; pc/count held; run restarts from base_addr
// ----------------------------------------------------------------------------
module instruction_fetcher #(
    parameter int                 BYTE_BITS   = 8,
    parameter int                 WIDTH       = 4 * BYTE_BITS,
    parameter int                 ADDR_WIDTH  = 8,
    parameter logic [BYTE_BITS-1:0] HALT_OPCODE = 8'hFF
) (
    input  logic                  clk,
    input  logic                  reset,
    instruction_fetcher_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_LATCH    = 3'd2,
        S_ISSUE    = 3'd3,
        S_WAIT_DEC = 3'd4,
        S_HALT     = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]           count_q, count_d;
    logic [WIDTH-1:0]      instr_q, instr_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            count_q <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        instr_d = instr_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (bus.run) begin
                    pc_d    = bus.base_addr;
                    count_d = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                instr_d = bus.imem_data;
                if (bus.imem_data[WIDTH-1 -: BYTE_BITS] == HALT_OPCODE) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT_DEC;
            S_WAIT_DEC: begin
                if (bus.decoder_ready) begin
                    // pc wraps naturally; the count sticks at all-ones
                    pc_d    = pc_q + ADDR_WIDTH'(1);
                    count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.imem_rd_en      = (state_q == S_FETCH);
    assign bus.decoder_start   = (state_q == S_ISSUE);
    assign bus.halted          = (state_q == S_HALT);
    assign bus.busy            = (state_q == S_FETCH) || (state_q == S_LATCH) ||
                                 (state_q == S_ISSUE) || (state_q == S_WAIT_DEC);
    assign bus.imem_addr       = pc_q;
    assign bus.pc              = pc_q;
    assign bus.instr_count     = count_q;
    assign bus.instruction_out = instr_q;

endmodule

// File: tb/tb_instruction_fetcher.sv
module tb_instruction_fetcher;

    logic clk;
    logic reset;

    instruction_fetcher_if #(.WIDTH(32), .ADDR_WIDTH(8)) bus ();

    instruction_fetcher dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // memory model: data valid the cycle after the read strobe
    logic [31:0] mem [256];
    logic [31:0] mem_data_q;
    always @(posedge clk) begin
        if (bus.imem_rd_en) mem_data_q <= mem[bus.imem_addr];
    end
    assign bus.imem_data = mem_data_q;

    // decoder model: ready pulses dec_lat cycles after start (0 = never)
    int   dec_lat;
    int   dec_cnt;
    logic ready_auto;
    logic force_ready;
    initial begin
        dec_cnt    = 0;
        ready_auto = 1'b0;
    end
    always @(negedge clk) begin
        ready_auto = 1'b0;
        if (bus.decoder_start) begin
            dec_cnt = dec_lat;
        end else if (dec_cnt > 0) begin
            dec_cnt = dec_cnt - 1;
            if (dec_cnt == 0) ready_auto = 1'b1;
        end
    end
    assign bus.decoder_ready = ready_auto | force_ready;

    // monitor: every fetched address, every issued instruction
    logic [7:0]  fetch_q [$];
    logic [31:0] issue_q [$];
    logic        prev_start;
    int          dbl_start;
    initial begin
        prev_start = 1'b0;
        dbl_start  = 0;
    end
    always @(negedge clk) begin
        if (bus.imem_rd_en) fetch_q.push_back(bus.imem_addr);
        if (bus.decoder_start) begin
            issue_q.push_back(bus.instruction_out);
            if (prev_start) dbl_start = dbl_start + 1;
        end
        prev_start = bus.decoder_start;
    end

    int n_tests;
    int n_fail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference model: walk memory until the halt opcode
    logic [7:0]  exp_fetch [$];
    logic [31:0] exp_issue [$];
    logic [7:0]  exp_pc;
    int          exp_cnt;

    task automatic model(input logic [7:0] base);
        logic [7:0] a;
        int         n;
        a = base;
        n = 0;
        exp_fetch.delete();
        exp_issue.delete();
        for (int g = 0; g < 600; g++) begin
            exp_fetch.push_back(a);
            if (mem[a][31:24] == 8'hFF) break;
            exp_issue.push_back(mem[a]);
            a = a + 8'd1;
            n = (n < 65535) ? n + 1 : n;
        end
        exp_pc  = a;
        exp_cnt = n;
    endtask

    task automatic wait_halt(input string tag);
        int cyc;
        cyc = 0;
        while (!bus.halted && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_timeout"}, 64'(cyc >= 3000), 64'd0);
    endtask

    // caller is at a negedge with the DUT in IDLE or HALT
    task automatic run_and_check(input logic [7:0] base, input int lat, input string tag);
        int f0;
        int i0;
        model(base);
        dec_lat = lat;
        f0 = fetch_q.size();
        i0 = issue_q.size();
        bus.base_addr = base;
        bus.run = 1'b1;
        @(negedge clk);
        bus.run = 1'b0;
        check({tag, "_cnt_clr"}, 64'(bus.instr_count), 64'd0);
        check({tag, "_first_addr"}, 64'(bus.imem_addr), 64'(base));
        wait_halt(tag);
        check({tag, "_nfetch"}, 64'(fetch_q.size() - f0), 64'(exp_fetch.size()));
        for (int k = 0; k < exp_fetch.size(); k++)
            if (f0 + k < fetch_q.size())
                check({tag, "_faddr"}, 64'(fetch_q[f0 + k]), 64'(exp_fetch[k]));
        check({tag, "_nissue"}, 64'(issue_q.size() - i0), 64'(exp_issue.size()));
        for (int k = 0; k < exp_issue.size(); k++)
            if (i0 + k < issue_q.size())
                check({tag, "_instr"}, 64'(issue_q[i0 + k]), 64'(exp_issue[k]));
        check({tag, "_pc"}, 64'(bus.pc), 64'(exp_pc));
        check({tag, "_count"}, 64'(bus.instr_count), 64'(exp_cnt));
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic wait_start(input string tag);
        int cyc;
        cyc = 0;
        while (!bus.decoder_start && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_start_seen"}, 64'(bus.decoder_start), 64'd1);
    endtask

    typedef struct {
        logic [7:0] base;
        int         len;
        int         lat;
        logic [7:0] exp_pc;
        int         exp_cnt;
    } vec_t;

    vec_t vecs [4];

    initial begin
        logic [31:0] instr0;
        logic [7:0]  pc0;
        int          bad;
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b0;
        bus.run = 1'b0;
        bus.base_addr = 8'h00;
        force_ready = 1'b0;
        dec_lat = 0;
        for (int k = 0; k < 256; k++) mem[k] = 32'h0;

        vecs[0] = '{8'h10, 1, 3, 8'h11, 1};
        vecs[1] = '{8'hFF, 2, 2, 8'h01, 2};
        vecs[2] = '{8'h40, 0, 1, 8'h40, 0};
        vecs[3] = '{8'h80, 5, 1, 8'h85, 5};

        // reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_halted", 64'(bus.halted), 64'd0);
        check("rst_pc", 64'(bus.pc), 64'd0);
        check("rst_count", 64'(bus.instr_count), 64'd0);
        check("rst_instr", 64'(bus.instruction_out), 64'd0);
        check("rst_rd_en", 64'(bus.imem_rd_en), 64'd0);
        check("rst_start", 64'(bus.decoder_start), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // table-driven programs
        foreach (vecs[v]) begin
            for (int i = 0; i < vecs[v].len; i++)
                mem[8'(vecs[v].base + 8'(i))] = {8'h91 + 8'(i), 24'h000000 + 24'(v)};
            mem[8'(vecs[v].base + 8'(vecs[v].len))] = 32'hFF00_0000;
            run_and_check(vecs[v].base, vecs[v].lat, $sformatf("vec%0d", v));
            check($sformatf("vec%0d_tbl_pc", v), 64'(bus.pc), 64'(vecs[v].exp_pc));
            check($sformatf("vec%0d_tbl_cnt", v), 64'(bus.instr_count), 64'(vecs[v].exp_cnt));
            check($sformatf("vec%0d_halted", v), 64'(bus.halted), 64'd1);
        end

        // start-cycle timing: run sampled at edge N
        mem[8'h30] = 32'h1234_5678;
        mem[8'h31] = 32'hFF00_0001;
        dec_lat = 2;
        bus.base_addr = 8'h30;
        bus.run = 1'b1;
        @(negedge clk);
        bus.run = 1'b0;
        check("t1_rd_en", 64'(bus.imem_rd_en), 64'd1);
        check("t1_addr", 64'(bus.imem_addr), 64'h30);
        @(negedge clk);
        check("t2_rd_en", 64'(bus.imem_rd_en), 64'd0);
        check("t2_start", 64'(bus.decoder_start), 64'd0);
        @(negedge clk);
        check("t3_start", 64'(bus.decoder_start), 64'd1);
        check("t3_instr", 64'(bus.instruction_out), 64'h1234_5678);
        @(negedge clk);
        check("t4_start", 64'(bus.decoder_start), 64'd0);
        check("t4_busy", 64'(bus.busy), 64'd1);
        wait_halt("timing");
        check("timing_pc", 64'(bus.pc), 64'h31);

        // stall with decoder_ready withheld; run pulsed while busy
        mem[8'h50] = 32'h0A0B_0C0D;
        mem[8'h51] = 32'h1111_2222;
        mem[8'h52] = 32'hFF00_0000;
        mem[8'h70] = 32'hFF00_0070;
        dec_lat = 0;
        bus.base_addr = 8'h50;
        bus.run = 1'b1;
        @(negedge clk);
        bus.run = 1'b0;
        wait_start("stall");
        @(negedge clk);
        instr0 = bus.instruction_out;
        pc0 = bus.pc;
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            bus.base_addr = 8'h70;
            bus.run = (c == 10);
            @(negedge clk);
            if (bus.instruction_out !== instr0 || bus.pc !== pc0 ||
                bus.decoder_start !== 1'b0 || bus.busy !== 1'b1) bad++;
        end
        bus.run = 1'b0;
        check("stall_hold", 64'(bad), 64'd0);
        check("stall_instr", 64'(instr0), 64'h0A0B_0C0D);
        force_ready = 1'b1;
        dec_lat = 2;
        @(negedge clk);
        force_ready = 1'b0;
        check("stall_refetch", 64'(bus.imem_rd_en), 64'd1);
        check("stall_pc_inc", 64'(bus.pc), 64'h51);
        wait_halt("stall");
        check("stall_count", 64'(bus.instr_count), 64'd2);
        check("stall_pc_end", 64'(bus.pc), 64'h52);

        // restart from HALT at 0x20
        mem[8'h20] = 32'h2020_2020;
        mem[8'h21] = 32'hFF00_0021;
        run_and_check(8'h20, 3, "restart");

        // async reset mid-WAIT_DEC
        mem[8'h60] = 32'h6060_6060;
        mem[8'h61] = 32'hFF00_0061;
        dec_lat = 0;
        bus.base_addr = 8'h60;
        bus.run = 1'b1;
        @(negedge clk);
        bus.run = 1'b0;
        wait_start("arst");
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_pc", 64'(bus.pc), 64'd0);
        check("arst_count", 64'(bus.instr_count), 64'd0);
        check("arst_instr", 64'(bus.instruction_out), 64'd0);
        check("arst_halted", 64'(bus.halted), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        force_ready = 1'b1;
        @(negedge clk);
        force_ready = 1'b0;
        @(negedge clk);
        check("arst_ready_ign_busy", 64'(bus.busy), 64'd0);
        check("arst_ready_ign_pc", 64'(bus.pc), 64'd0);
        run_and_check(8'h60, 2, "arst_rerun");

        // randomized programs against the model
        for (int r = 0; r < 8; r++) begin
            logic [7:0] b;
            int         len;
            b = 8'($urandom_range(0, 255));
            len = $urandom_range(0, 12);
            for (int k = 0; k < 256; k++) mem[k] = $urandom;
            mem[8'(b + 8'(len))] = {8'hFF, 24'($urandom)};
            run_and_check(b, $urandom_range(1, 5), $sformatf("rnd%0d", r));
        end

        check("double_start", 64'(dbl_start), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
